// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a dual-clock FIFO: write-pointer synchroniser, read pointer,
// empty/level decode, and a 2-entry skid buffer turning the registered array read into a stream.
module fifo_rd_ctrl #(
    parameter int FIFO_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_i,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [FIFO_WIDTH-1:0] mem_rd_data,
    output logic                  mem_empty,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray_o,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  wr_ptr_sync;
    logic [PW-1:0]                  wr_bin;

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         rd_gray_q, rd_gray_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_q [2];
    logic [FIFO_WIDTH-1:0] data_d [2];

    logic empty;
    logic issue;
    logic push;
    logic pop;

    assign wr_ptr_sync = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wr_bin = '0;
        for (int i = 0; i < PW; i++) begin
            wr_bin[i] = ^(wr_ptr_sync >> i);
        end
    end

    // Both operands are flops, so empty cannot glitch while pointers roll over.
    assign empty = (rd_gray_q == wr_ptr_sync);

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q;

    // A read is issued only if the buffer is guaranteed a free slot when its data lands.
    assign issue = !empty &&
                   ((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || pop);

    // NOTE: every combinational output gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, issue};
        rd_gray_d  = rd_ptr_d ^ (rd_ptr_d >> 1);
        inflight_d = issue;
        count_d    = count_q;
        data_d     = data_q;

        case ({push, pop})
            2'b01: begin
                data_d[0] = data_q[1];
                count_d   = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    data_d[0] = mem_rd_data;
                end else begin
                    data_d[1] = mem_rd_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    data_d[0] = mem_rd_data;
                end else begin
                    data_d[0] = data_q[1];
                    data_d[1] = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gray_i};
        end
    end

    // NOTE: the two-entry buffer is reset along with the control state; this is cheap at this
    // size and keeps out_data deterministic, unlike a large storage array which is left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            rd_gray_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_gray_q  <= rd_gray_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            data_q[0]  <= data_d[0];
            data_q[1]  <= data_d[1];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && count_q == 2'd2))
                else $error("buffer overflow: push into full buffer");
        end
    end
`endif

    assign mem_rd_en     = issue;
    assign mem_rd_addr   = rd_ptr_q[ADDR_WIDTH-1:0];
    assign mem_empty     = empty;
    assign rd_ptr_gray_o = rd_gray_q;
    assign out_data      = out_valid ? data_q[0] : '0;
    assign level         = wr_bin - rd_ptr_q;

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock FIFO storage array. It runs entirely in the read clock domain and synchronises the Gray-coded write pointer from the write side. It owns the read pointer, generates the empty flag, and drives the array's read enable and read address. It converts the array's one-cycle registered read into a valid/ready stream through a 2-entry output buffer, and returns its Gray read pointer to the write side.

Parameters:
FIFO_WIDTH, 4, data word width
ADDR_WIDTH, 3, array address width; depth = 2^ADDR_WIDTH (8)
SYNC_STAGES, 2, flops in the write-pointer synchroniser (>=2)

Ports:
clk  in  1  read-domain clock; all flops posedge
rst_n  in  1  asynchronous active-low reset
wr_ptr_gray_i  in  ADDR_WIDTH+1  Gray write pointer from the write domain (asynchronous)
mem_rd_en  out  1  read enable to the array
mem_rd_addr  out  ADDR_WIDTH  read address to the array
mem_rd_data  in  FIFO_WIDTH  array read data, valid the cycle after mem_rd_en
mem_empty  out  1  empty flag to the array
rd_ptr_gray_o  out  ADDR_WIDTH+1  registered Gray read pointer to the write domain
out_valid  out  1  stream data valid
out_ready  in  1  stream consumer ready
out_data  out  FIFO_WIDTH  stream data
level  out  ADDR_WIDTH+1  entries in the array not yet issued for read

Behaviour:
- Reset (async assert, sync release): synchroniser flops, rd_ptr, inflight and buffer all clear to 0. Outputs after reset: mem_rd_en=0, mem_rd_addr=0, mem_empty=1, rd_ptr_gray_o=0, out_valid=0, out_data=0, level=0.
- Synchroniser: wr_ptr_gray_i passes through SYNC_STAGES flops to give wr_ptr_sync. Its Gray-to-binary conversion gives wr_bin.
- Read pointer: rd_ptr is binary, ADDR_WIDTH+1 bits, and wraps modulo 2^(ADDR_WIDTH+1). rd_ptr_gray_o = rd_ptr ^ (rd_ptr>>1), registered and updated in the same edge as rd_ptr.
- Empty flag: empty = (rd_ptr_gray_o == wr_ptr_sync), decoded from registers only. mem_empty = empty.
- Level: level = wr_bin - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Issue condition: issue = !empty && ((count + inflight < 2) || (out_valid && out_ready)).
  - count is the number of buffer entries (0..2).
  - inflight is a 1-bit register, set to issue each cycle.
- Array read: mem_rd_en = issue and mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0], both combinational. On issue, rd_ptr increments at the next edge.
- Capture: the cycle after issue (inflight=1), mem_rd_data is pushed into the buffer tail at the edge.
- Stream output: out_valid = (count != 0). out_data = head entry when valid, 0 otherwise. Pop occurs when out_valid && out_ready.
- Simultaneous push and pop in one cycle is legal; count is unchanged and order is preserved.
- Stability: while out_valid=1 and out_ready=0, out_valid and out_data hold stable.
- Throughput: one word per cycle sustained when out_ready=1 and the FIFO is non-empty.
- Latency: a wr_ptr_gray_i change before edge E0 makes out_valid rise after edge E0+SYNC_STAGES+1, i.e. 4 edges at SYNC_STAGES=2.
- Backpressure: at most 2 words are held (buffer plus inflight). No read is issued when the buffer cannot accept the word.
- Wrap-around: rd_ptr rolls from 2^(ADDR_WIDTH+1)-1 to 0 with no change in behaviour and no empty glitch.
- Reset mid-operation: buffered and inflight words are discarded and all outputs return to reset values immediately. The write side must be reset together with this block.
- Out-of-range input: wr_ptr advancing more than 2^ADDR_WIDTH past rd_ptr is illegal; behaviour is undefined.

Test Plan:
1. Reset: pulse rst_n low mid-clock -> all outputs at reset values immediately; mem_empty=1, rd_ptr_gray_o=0.
2. Single word: MEM[0]=4'hA; wr_ptr_gray_i 0000->0001; out_ready=1 -> mem_rd_en high one cycle with addr 0; out_valid=1 with out_data=A for one cycle, 4 edges after the change; then rd_ptr_gray_o=0001, mem_empty=1.
3. Backpressure: MEM[0..7]=1..8; wr_ptr_gray_i=1100 (binary 8); out_ready=0 -> exactly 2 reads issued; out_valid=1 with data 1 held stable; level=6. Raise out_ready -> 1..8 delivered back-to-back, one per cycle.
4. Wrap: stream 20 words with continuous writes and out_ready=1 -> rd_ptr_gray_o goes 1000->0000 at rollover; data in order; no lost or duplicated words; no false empty.
5. Random: random writer and random out_ready against a reference queue -> every word delivered exactly once, in order; out_data never changes while stalled.
6. Reset mid-stream: with count=2, assert rst_n=0 -> out_valid=0 asynchronously. After release, writing 1 word yields exactly that word.
